nl2_cln_vchan_snd_arb: RTL and testbench

Sender-side virtual-channel multiplexer that feeds the physical channel sender port.
- Accepts NCHAN independent valid/ready virtual-channel streams.
- Tracks per-channel credits from cumulative credit counts returned by the downstream physical channel.
- Round-robin arbitrates among channels that have both data and credit, and presents one registered cell per cycle with its channel identifier.

---
 rtl/nl2_cln_vchan_snd_arb_if.sv | 31 +++
 rtl/nl2_cln_vchan_snd_arb.sv | 111 +++++++++++
 tb/tb_nl2_cln_vchan_snd_arb.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/nl2_cln_vchan_snd_arb_if.sv
// Purpose: bundles the virtual-channel inputs and the physical-channel output of the sender arbiter.
// Latency: none; wires only.
// Backpressure: per-channel valid/ready on the sources, valid/accept toward the physical channel.
interface nl2_cln_vchan_snd_arb_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NCHAN      = 4,
    parameter int CRDSZ      = 4
);
    localparam int VCHAN_ID_SZ = (NCHAN < 2) ? 1 : $clog2(NCHAN);

    logic [NCHAN-1:0]            vc_valid;
    logic [NCHAN*DATA_WIDTH-1:0] vc_data;
    logic [NCHAN-1:0]            vc_ready;
    logic [NCHAN*CRDSZ-1:0]      credit;
    logic [DATA_WIDTH-1:0]       payload;
    logic [VCHAN_ID_SZ-1:0]      chan_id;
    logic                        valid;
    logic                        accept;

    // master: the arbiter itself, driving ready toward sources and cells toward the channel
    modport master (
        input  vc_valid, vc_data, credit, accept,
        output vc_ready, payload, chan_id, valid
    );

    // slave: the surrounding sources, credit return path and physical channel sink
    modport slave (
        output vc_valid, vc_data, credit, accept,
        input  vc_ready, payload, chan_id, valid
    );
endinterface

// File: rtl/nl2_cln_vchan_snd_arb.sv
// Purpose: round-robin mux of NCHAN credit-gated virtual channels onto one physical sender port.
// Latency: 1 cycle from grant to valid; 1 cell/cycle sustained while accept stays high.
// Backpressure: output register holds while valid & ~accept; a channel stalls when its credit is spent.
module nl2_cln_vchan_snd_arb #(
    parameter int DATA_WIDTH = 64,
    parameter int NCHAN      = 4,
    parameter int CRDSZ      = 4
) (
    input  logic                    clk,
    input  logic                    rst_a,
    nl2_cln_vchan_snd_arb_if.master bus
);
    localparam int VCHAN_ID_SZ = (NCHAN < 2) ? 1 : $clog2(NCHAN);

    typedef logic [VCHAN_ID_SZ-1:0] id_t;
    typedef logic [CRDSZ-1:0]       cnt_t;

    cnt_t                  sent_cnt [NCHAN];
    cnt_t                  avail    [NCHAN];
    logic [NCHAN-1:0]      elig;
    logic [NCHAN-1:0]      dry;
    logic [NCHAN-1:0]      grant;
    logic                  any_grant;
    logic                  load;
    id_t                   last_grant;
    id_t                   gnt_id;
    logic [DATA_WIDTH-1:0] gnt_dat;

    logic                  out_vld;
    logic [DATA_WIDTH-1:0] out_dat;
    id_t                   out_id;

    // Credits left per channel: modular difference of the two cumulative counters, wrap-safe
    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            avail[c] = bus.credit[c*CRDSZ +: CRDSZ] - sent_cnt[c];
            dry[c]   = (avail[c] == '0);
            elig[c]  = bus.vc_valid[c] & ~dry[c];
        end
    end

    // Output slot is free, or the cell in it leaves this cycle
    assign load = ~out_vld | bus.accept;

    // Round-robin pick: first eligible channel scanning upward from last_grant+1 with wrap
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        any_grant = 1'b0;
        gnt_id    = '0;
        gnt_dat   = '0;
        for (int i = 1; i <= NCHAN; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NCHAN) idx = idx - NCHAN;
            if (!any_grant && elig[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                gnt_id     = id_t'(idx);
                gnt_dat    = bus.vc_data[idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.vc_ready = load ? grant : '0;
    assign bus.valid    = out_vld;
    assign bus.payload  = out_dat;
    assign bus.chan_id  = out_id;

    // Output register and priority pointer; payload/id keep their last value when the slot empties
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            out_vld    <= 1'b0;
            out_dat    <= '0;
            out_id     <= '0;
            last_grant <= id_t'(NCHAN - 1);
        end else if (load) begin
            if (any_grant) begin
                out_vld    <= 1'b1;
                out_dat    <= gnt_dat;
                out_id     <= gnt_id;
                last_grant <= gnt_id;
            end else begin
                out_vld    <= 1'b0;
            end
        end
    end

    // Cells handed to the physical channel, per virtual channel, counted modulo 2^CRDSZ
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            for (int c = 0; c < NCHAN; c++) sent_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                if (load && grant[c]) sent_cnt[c] <= sent_cnt[c] + cnt_t'(1);
            end
        end
    end

    // At most one source is served per cycle
    a_ready_onehot0: assert property (@(posedge clk) disable iff (rst_a)
        $onehot0(bus.vc_ready));

    // A stalled cell stays put until the channel takes it
    a_hold_stable: assert property (@(posedge clk) disable iff (rst_a)
        (out_vld && !bus.accept) |=> (out_vld && $stable(out_dat) && $stable(out_id)));

    // A channel with no credit is never served, so avail cannot underflow to all-ones
    a_no_underflow: assert property (@(posedge clk) disable iff (rst_a)
        ((bus.vc_ready & dry) == '0));
endmodule

// File: tb/tb_nl2_cln_vchan_snd_arb.sv
// Purpose: directed scoreboard bench for the virtual-channel sender arbiter (NCHAN=4, CRDSZ=4).
// Latency: expects each granted cell on the output one cycle after its source handshake.
// Backpressure: drives accept low to stall the output and withholds credit to stall channels.
module tb_nl2_cln_vchan_snd_arb;
    localparam int DW = 64;
    localparam int NC = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic [3:0]    ch;
        logic [DW-1:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a;

    nl2_cln_vchan_snd_arb_if #(.DATA_WIDTH(DW), .NCHAN(NC), .CRDSZ(CW)) bus ();

    nl2_cln_vchan_snd_arb #(.DATA_WIDTH(DW), .NCHAN(NC), .CRDSZ(CW)) dut (
        .clk   (clk),
        .rst_a (rst_a),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    int          seq  [NC] = '{default: 0};
    int          eseq [NC] = '{default: 0};
    logic [CW-1:0] cr [NC] = '{default: '0};

    function automatic logic [DW-1:0] mk(int c, int s);
        return {8'(c), 24'hC0FFEE, 32'(s)};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cr();
        for (int c = 0; c < NC; c++) bus.credit[c*CW +: CW] = cr[c];
    endtask

    task automatic push(input int c);
        sb.push_back('{ch: 4'(c), dat: mk(c, eseq[c])});
        eseq[c]++;
    endtask

    // One clock: score the output at negedge, then advance every source whose cell was taken
    task automatic cyc();
        logic [NC-1:0] rdy;
        exp_t          e;
        @(negedge clk);
        if (bus.valid && bus.accept) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_cell: got chan %0d payload %0h, want no cell", bus.chan_id, bus.payload);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_chan_id", 64'(bus.chan_id), 64'(e.ch));
                chk("out_payload", bus.payload, e.dat);
            end
        end
        rdy = bus.vc_ready;
        chk("vc_ready_onehot0", 64'($onehot0(rdy)), 64'd1);
        @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            if (rdy[c]) begin
                seq[c]++;
                bus.vc_data[c*DW +: DW] = mk(c, seq[c]);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst_a        = 1'b1;
        bus.vc_valid = '0;
        bus.accept   = 1'b0;
        for (int c = 0; c < NC; c++) cr[c] = '0;
        drive_cr();
        run(2);
        rst_a = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
        chk({tag, "_valid_low"}, 64'(bus.valid), 64'd0);
    endtask

    initial begin
        rst_a        = 1'b1;
        bus.vc_valid = '0;
        bus.accept   = 1'b0;
        for (int c = 0; c < NC; c++) bus.vc_data[c*DW +: DW] = mk(c, 0);
        drive_cr();
        #2;
        chk("rst_valid", 64'(bus.valid), 64'd0);
        chk("rst_payload", bus.payload, 64'd0);
        chk("rst_chan_id", 64'(bus.chan_id), 64'd0);
        chk("rst_vc_ready", 64'(bus.vc_ready), 64'd0);
        do_reset();

        // Single channel limited to 3 credits, then one more
        cr[0] = 4'd3; drive_cr();
        bus.vc_valid = 4'b0001;
        bus.accept   = 1'b1;
        repeat (3) push(0);
        run(6);
        chk_idle("ch0_credit3");
        chk("ch0_blocked_ready", 64'(bus.vc_ready), 64'd0);
        cr[0] = 4'd4; drive_cr();
        push(0);
        run(4);
        chk_idle("ch0_credit4");

        // All channels, 2 credits each: strict round robin from channel 0
        do_reset();
        for (int c = 0; c < NC; c++) cr[c] = 4'd2;
        drive_cr();
        bus.vc_valid = 4'b1111;
        bus.accept   = 1'b1;
        for (int r = 0; r < 2; r++) for (int c = 0; c < NC; c++) push(c);
        run(12);
        chk_idle("rr_all");

        // Output stall: cell held stable, no source served, then resumes without a bubble
        do_reset();
        cr[0] = 4'd2; drive_cr();
        bus.vc_valid = 4'b0001;
        bus.accept   = 1'b0;
        push(0); push(0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("hold_valid", 64'(bus.valid), 64'd1);
            chk("hold_payload", bus.payload, sb[0].dat);
            chk("hold_chan_id", 64'(bus.chan_id), 64'(sb[0].ch));
            chk("hold_vc_ready", 64'(bus.vc_ready), 64'd0);
        end
        bus.accept = 1'b1;
        cyc();
        chk("b2b_valid", 64'(bus.valid), 64'd1);
        chk("b2b_payload", bus.payload, sb[0].dat);
        run(3);
        chk_idle("stall");

        // Counter wrap: channel 1 gets 15 credits, then cumulative count wraps to 4 (5 more)
        do_reset();
        cr[1] = 4'd15; drive_cr();
        bus.vc_valid = 4'b0010;
        bus.accept   = 1'b1;
        repeat (15) push(1);
        run(18);
        chk_idle("wrap_first15");
        chk("wrap_blocked_ready", 64'(bus.vc_ready), 64'd0);
        cr[1] = 4'd4; drive_cr();
        repeat (5) push(1);
        run(8);
        chk_idle("wrap_next5");
        chk("wrap_end_ready", 64'(bus.vc_ready), 64'd0);

        // Channel 2 valid but creditless: 0 and 3 alternate, 2 starts right after its credit arrives
        do_reset();
        cr[0] = 4'd2; cr[3] = 4'd2; drive_cr();
        bus.vc_valid = 4'b1101;
        bus.accept   = 1'b1;
        push(0); push(3); push(0); push(3);
        run(6);
        chk_idle("skip_ch2");
        chk("ch2_blocked_ready", 64'(bus.vc_ready), 64'd0);
        cr[2] = 4'd1; drive_cr();
        push(2);
        cyc();
        chk("ch2_start_valid", 64'(bus.valid), 64'd1);
        chk("ch2_start_chan", 64'(bus.chan_id), 64'd2);
        run(3);
        chk_idle("ch2_done");

        // Asynchronous reset while a stalled cell is pending
        do_reset();
        cr[0] = 4'd1; drive_cr();
        bus.vc_valid = 4'b0001;
        bus.accept   = 1'b0;
        push(0);
        cyc();
        chk("pre_rst_valid", 64'(bus.valid), 64'd1);
        rst_a        = 1'b1;
        bus.vc_valid = '0;
        for (int c = 0; c < NC; c++) cr[c] = '0;
        drive_cr();
        #1;
        chk("async_rst_valid", 64'(bus.valid), 64'd0);
        chk("async_rst_payload", bus.payload, 64'd0);
        chk("async_rst_chan", 64'(bus.chan_id), 64'd0);
        sb.delete();
        run(2);
        rst_a = 1'b0;
        for (int c = 0; c < NC; c++) cr[c] = 4'd1;
        drive_cr();
        bus.vc_valid = 4'b1111;
        bus.accept   = 1'b1;
        for (int c = 0; c < NC; c++) push(c);
        run(7);
        chk_idle("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
